lenet_axil_stream_slave: RTL and testbench

LENET_AXIL_STREAM_SLAVE -- requirements
Module: lenet_axil_stream_slave

---
 rtl/lenet_axil_stream_slave.sv | 166 ++++++++++++++++
 tb/tb_lenet_axil_stream_slave.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lenet_axil_stream_slave.sv
// lenet_axil_stream_slave: AXI4-Lite control/status slave feeding per-channel FWFT stream FIFOs
module lenet_axil_stream_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_CH = 3,
    parameter int FIFO_DEPTH = 16,
    parameter int BLOCK_ON_FULL = 1
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [NUM_CH*32-1:0]            m_tdata,
    output logic [NUM_CH-1:0]               m_tvalid,
    input  logic [NUM_CH-1:0]               m_tready,
    output logic                            start_o,
    output logic                            soft_clear_o,
    input  logic                            done_i,
    input  logic [31:0]                     result_i,
    output logic                            irq_o
);
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [3:0]        aw_idx, ar_idx;
    logic [NUM_CH-1:0] full, empty, pop, wsel, push;
    logic [7:0]        full8, empty8;
    logic              wr_hs, ctrl_wr, stat_wr, irq_wr, blocked, drop, clr, start_fire;
    logic              done, busy, ovf, irq_en;
    logic [31:0]       result, status, rd_val;
    logic              unused;

    assign unused  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
    assign aw_idx  = S_AXI_AWADDR[5:2];
    assign ar_idx  = S_AXI_ARADDR[5:2];
    assign wr_hs   = S_AXI_AWREADY & S_AXI_AWVALID & S_AXI_WVALID;
    assign ctrl_wr = wr_hs & (aw_idx == 4'd0);
    assign stat_wr = wr_hs & (aw_idx == 4'd1);
    assign irq_wr  = wr_hs & (aw_idx == 4'd3);
    // A pop in the same cycle frees a slot, so a full FIFO being drained still accepts the push.
    assign blocked = (BLOCK_ON_FULL != 0) && |(wsel & full & ~pop);
    assign drop    = (BLOCK_ON_FULL == 0) && wr_hs && |(wsel & full & ~pop);
    assign clr     = ctrl_wr & S_AXI_WDATA[1];
    assign start_fire = ctrl_wr & S_AXI_WDATA[0] & ~busy;
    assign S_AXI_RRESP = 2'b00;

    genvar k;
    generate
        for (k = 0; k < NUM_CH; k++) begin : g_fifo
            logic [31:0] mem [FIFO_DEPTH];
            logic [PW:0] wp, rp;
            assign wsel[k]     = aw_idx == 4'(k + 4);
            assign empty[k]    = wp == rp;
            assign full[k]     = wp == {~rp[PW], rp[PW-1:0]};
            assign pop[k]      = ~empty[k] & m_tready[k];
            assign push[k]     = wr_hs & wsel[k] & (~full[k] | pop[k]);
            assign m_tvalid[k] = ~empty[k];
            assign m_tdata[32*k +: 32] = mem[rp[PW-1:0]];
            // Pointer update; soft clear flushes by rewinding both pointers.
            always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
                if (!S_AXI_ARESETN) begin
                    wp <= '0;
                    rp <= '0;
                end else if (clr) begin
                    wp <= '0;
                    rp <= '0;
                end else begin
                    if (push[k]) wp <= wp + 1'b1;
                    if (pop[k])  rp <= rp + 1'b1;
                end
            end
            // Storage array, written at the tail pointer.
            always_ff @(posedge S_AXI_ACLK) begin
                if (push[k]) mem[wp[PW-1:0]] <= S_AXI_WDATA[31:0];
            end
        end
    endgenerate

    // Widen per-channel flags to the fixed 8-bit STATUS fields.
    always_comb begin
        full8  = '0;
        empty8 = '0;
        full8[NUM_CH-1:0]  = full;
        empty8[NUM_CH-1:0] = empty;
    end

    assign status = {8'h0, full8, empty8, 5'h0, ovf, busy, done};
    assign rd_val = ar_idx == 4'd1 ? status :
                    ar_idx == 4'd2 ? result :
                    ar_idx == 4'd3 ? {31'h0, irq_en} : 32'h0;

    // Write channel: single-cycle AW/W ready pulse, one outstanding B response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b0;
            S_AXI_BRESP   <= 2'b00;
        end else begin
            S_AXI_AWREADY <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY & ~blocked;
            S_AXI_WREADY  <= S_AXI_AWVALID & S_AXI_WVALID & ~S_AXI_BVALID & ~S_AXI_AWREADY & ~blocked;
            if (wr_hs) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= drop ? 2'b10 : 2'b00;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Read channel: single-cycle AR ready pulse, data held until accepted.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b0;
            S_AXI_RDATA   <= '0;
        end else begin
            S_AXI_ARREADY <= S_AXI_ARVALID & ~S_AXI_RVALID & ~S_AXI_ARREADY;
            if (S_AXI_ARREADY & S_AXI_ARVALID) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_val;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Control/status state: pulses, busy/done/overflow flags, result and interrupt.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            start_o      <= 1'b0;
            soft_clear_o <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            result       <= '0;
            irq_en       <= 1'b0;
            irq_o        <= 1'b0;
        end else begin
            start_o      <= start_fire;
            soft_clear_o <= clr;
            busy         <= start_fire | (busy & ~done_i & ~clr);
            done         <= ~clr & (done_i | (done & ~(stat_wr & S_AXI_WDATA[0])));
            ovf          <= ~clr & (drop | (ovf & ~(stat_wr & S_AXI_WDATA[2])));
            if (done_i) result <= result_i;
            if (irq_wr) irq_en <= S_AXI_WDATA[0];
            irq_o        <= done & irq_en;
        end
    end
endmodule

// File: tb/tb_lenet_axil_stream_slave.sv
// tb_lenet_axil_stream_slave: randomized, model-checked bench for the AXI-Lite stream slave
module tb_lenet_axil_stream_slave;
    logic clk = 0, rst_n = 0;
    always #5 clk = ~clk;

    logic [5:0]  awaddr = '0, araddr = '0;
    logic [31:0] wdata = '0, result_in = '0;
    logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, done_in = 0, sel = 0;
    logic [2:0]  tready = '0;

    logic        aw_rdy [2], w_rdy [2], b_vld [2], ar_rdy [2], r_vld [2], start [2], sclr [2], irq [2];
    logic [1:0]  b_resp [2], r_resp [2];
    logic [31:0] r_data [2];
    logic [95:0] tdata [2];
    logic [2:0]  tvalid [2];

    int n_cmp = 0, n_fail = 0;
    logic [31:0] q [6][$];
    logic snap_start, snap_sclr, snap_start1, snap_sclr1;

    lenet_axil_stream_slave dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & !sel), .S_AXI_AWREADY(aw_rdy[0]),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid & !sel), .S_AXI_WREADY(w_rdy[0]),
        .S_AXI_BRESP(b_resp[0]), .S_AXI_BVALID(b_vld[0]), .S_AXI_BREADY(bready & !sel),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & !sel), .S_AXI_ARREADY(ar_rdy[0]),
        .S_AXI_RDATA(r_data[0]), .S_AXI_RRESP(r_resp[0]), .S_AXI_RVALID(r_vld[0]), .S_AXI_RREADY(rready & !sel),
        .m_tdata(tdata[0]), .m_tvalid(tvalid[0]), .m_tready(sel ? 3'b000 : tready),
        .start_o(start[0]), .soft_clear_o(sclr[0]), .done_i(done_in & !sel), .result_i(result_in), .irq_o(irq[0])
    );

    lenet_axil_stream_slave #(.BLOCK_ON_FULL(0)) dut_nb (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(3'b000), .S_AXI_AWVALID(awvalid & sel), .S_AXI_AWREADY(aw_rdy[1]),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(4'hF), .S_AXI_WVALID(wvalid & sel), .S_AXI_WREADY(w_rdy[1]),
        .S_AXI_BRESP(b_resp[1]), .S_AXI_BVALID(b_vld[1]), .S_AXI_BREADY(bready & sel),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(3'b000), .S_AXI_ARVALID(arvalid & sel), .S_AXI_ARREADY(ar_rdy[1]),
        .S_AXI_RDATA(r_data[1]), .S_AXI_RRESP(r_resp[1]), .S_AXI_RVALID(r_vld[1]), .S_AXI_RREADY(rready & sel),
        .m_tdata(tdata[1]), .m_tvalid(tvalid[1]), .m_tready(sel ? tready : 3'b000),
        .start_o(start[1]), .soft_clear_o(sclr[1]), .done_i(done_in & sel), .result_i(result_in), .irq_o(irq[1])
    );

    function automatic logic [31:0] exp_status(input bit dn, input bit bsy, input bit ov);
        logic [31:0] s;
        s = {29'h0, ov, bsy, dn};
        for (int c = 0; c < 3; c++) begin
            if (q[int'(sel)*3+c].size() == 0)  s[8+c] = 1'b1;
            if (q[int'(sel)*3+c].size() == 16) s[16+c] = 1'b1;
        end
        return s;
    endfunction

    task automatic axi_write(input logic [5:0] a, input logic [31:0] d, input bit pulse, output logic [1:0] resp);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
        do begin @(posedge clk); #1; n++; end while (!aw_rdy[sel] && n < 64);
        n_cmp++;
        if (!aw_rdy[sel] || !w_rdy[sel]) begin
            n_fail++;
            $display("FAIL wr_ready addr=%h awready=%b wready=%b required 1/1", a, aw_rdy[sel], w_rdy[sel]);
            awvalid = 0; wvalid = 0; resp = 2'bxx;
            return;
        end
        if (pulse) done_in = 1;
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0; done_in = 0;
        snap_start = start[sel]; snap_sclr = sclr[sel]; resp = b_resp[sel];
        n_cmp++;
        if (b_vld[sel] !== 1'b1) begin n_fail++; $display("FAIL bvalid_after_hs got %b required 1", b_vld[sel]); end
        bready = 1;
        @(posedge clk); #1;
        bready = 0; snap_start1 = start[sel]; snap_sclr1 = sclr[sel];
        n_cmp++;
        if (b_vld[sel] !== 1'b0) begin n_fail++; $display("FAIL bvalid_after_bready got %b required 0", b_vld[sel]); end
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1;
        do begin @(posedge clk); #1; n++; end while (!ar_rdy[sel] && n < 64);
        n_cmp++;
        if (!ar_rdy[sel]) begin
            n_fail++; $display("FAIL rd_arready addr=%h got 0 required 1", a);
            arvalid = 0; d = 'x;
            return;
        end
        @(posedge clk); #1;
        arvalid = 0;
        n_cmp++;
        if (r_vld[sel] !== 1'b1) begin n_fail++; $display("FAIL rvalid addr=%h got %b required 1", a, r_vld[sel]); end
        d = r_data[sel];
        rready = 1;
        @(posedge clk); #1;
        rready = 0;
    endtask

    task automatic push(input int ch, input logic [31:0] d);
        logic [1:0] r, er;
        int idx = int'(sel)*3 + ch;
        er = q[idx].size() < 16 ? 2'b00 : 2'b10;
        axi_write(6'(16 + 4*ch), d, 0, r);
        n_cmp++;
        if (r !== er) begin n_fail++; $display("FAIL push_resp ch=%0d got %b required %b", ch, r, er); end
        if (er == 2'b00) q[idx].push_back(d);
    endtask

    task automatic drain(input int ch, input int cnt);
        int idx = int'(sel)*3 + ch;
        logic [31:0] e;
        tready = 3'(1 << ch);
        for (int i = 0; i < cnt; i++) begin
            e = q[idx].pop_front();
            n_cmp++;
            if (tvalid[sel][ch] !== 1'b1 || tdata[sel][32*ch +: 32] !== e) begin
                n_fail++;
                $display("FAIL drain ch=%0d valid=%b data=%h required 1/%h", ch, tvalid[sel][ch], tdata[sel][32*ch +: 32], e);
            end
            @(posedge clk); #1;
        end
        tready = '0;
    endtask

    task automatic chk_reg(input logic [5:0] a, input logic [31:0] e, input string nm);
        logic [31:0] d;
        axi_read(a, d);
        n_cmp++;
        if (d !== e) begin n_fail++; $display("FAIL %s got %h required %h", nm, d, e); end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 6; i++) q[i].delete();
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            n_cmp++;
            if ({aw_rdy[s], w_rdy[s], b_vld[s], ar_rdy[s], r_vld[s], start[s], sclr[s], irq[s]} !== 8'h0 ||
                tvalid[s] !== 3'b0 || b_resp[s] !== 2'b0 || r_resp[s] !== 2'b0 || r_data[s] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs inst=%0d rdys=%b%b%b%b%b pulses=%b%b%b tvalid=%b rdata=%h required all 0",
                         s, aw_rdy[s], w_rdy[s], b_vld[s], ar_rdy[s], r_vld[s], start[s], sclr[s], irq[s], tvalid[s], r_data[s]);
            end
        end
        rst_n = 1;
        @(posedge clk); #1;
        clear_model();
        chk_reg(6'h04, exp_status(0, 0, 0), "reset_status");
        chk_reg(6'h08, 32'h0, "reset_result");
        chk_reg(6'h0C, 32'h0, "reset_irq_en");
    endtask

    task automatic test_unmapped();
        logic [1:0] r;
        chk_reg(6'h00, 32'h0, "ctrl_read_zero");
        chk_reg(6'h3C, 32'h0, "unmapped_read");
        chk_reg(6'h1C, 32'h0, "ch3_read");
        axi_write(6'h1C, 32'hDEAD_BEEF, 0, r);
        n_cmp++;
        if (r !== 2'b00 || tvalid[0] !== 3'b0) begin
            n_fail++; $display("FAIL ch3_write resp=%b tvalid=%b required 00/000", r, tvalid[0]);
        end
        chk_reg(6'h04, exp_status(0, 0, 0), "status_after_unmapped");
    endtask

    task automatic test_fifo_fill();
        for (int i = 0; i < 16; i++) push(0, 32'h11 + i);
        chk_reg(6'h04, exp_status(0, 0, 0), "ch0_full_status");
        drain(0, 16);
        chk_reg(6'h04, exp_status(0, 0, 0), "ch0_empty_status");
    endtask

    task automatic test_block();
        int n = 0;
        for (int i = 0; i < 16; i++) push(1, $urandom);
        awaddr = 6'h14; wdata = 32'hAA; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (aw_rdy[0] !== 1'b0) begin n_fail++; $display("FAIL block_awready cyc=%0d got %b required 0", i, aw_rdy[0]); end
        end
        tready = 3'b010;
        n_cmp++;
        if (tvalid[0][1] !== 1'b1 || tdata[0][63:32] !== q[1][0]) begin
            n_fail++; $display("FAIL block_pop data=%h required %h", tdata[0][63:32], q[1][0]);
        end
        void'(q[1].pop_front());
        @(posedge clk); #1;
        tready = '0;
        while (!aw_rdy[0] && n < 64) begin @(posedge clk); #1; n++; end
        n_cmp++;
        if (!aw_rdy[0]) begin n_fail++; $display("FAIL block_release awready=0 required 1"); end
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n_cmp++;
        if (b_vld[0] !== 1'b1 || b_resp[0] !== 2'b00) begin
            n_fail++; $display("FAIL block_bresp bvalid=%b bresp=%b required 1/00", b_vld[0], b_resp[0]);
        end
        bready = 1; @(posedge clk); #1; bready = 0;
        q[1].push_back(32'hAA);
        chk_reg(6'h04, exp_status(0, 0, 0), "block_full_again");
        drain(1, 16);
    endtask

    task automatic test_random();
        int ch;
        for (int it = 0; it < 60; it++) begin
            ch = $urandom_range(0, 2);
            if ($urandom_range(0, 2) != 0 && q[ch].size() < 16) push(ch, $urandom);
            else drain(ch, $urandom_range(0, q[ch].size()));
            if (it % 10 == 9) chk_reg(6'h04, exp_status(0, 0, 0), "random_status");
        end
        for (int c = 0; c < 3; c++) drain(c, q[c].size());
        chk_reg(6'h04, exp_status(0, 0, 0), "random_final_status");
    endtask

    task automatic test_drop();
        sel = 1;
        for (int i = 0; i < 16; i++) push(2, $urandom);
        push(2, 32'hBB);
        chk_reg(6'h04, exp_status(0, 0, 1), "drop_overflow_set");
        begin
            logic [1:0] r;
            axi_write(6'h04, 32'h4, 0, r);
        end
        chk_reg(6'h04, exp_status(0, 0, 0), "drop_overflow_w1c");
        drain(2, 16);
        n_cmp++;
        if (tvalid[1][2] !== 1'b0) begin n_fail++; $display("FAIL drop_not_emitted tvalid=%b required 0", tvalid[1][2]); end
        sel = 0;
    endtask

    task automatic test_start_done();
        logic [1:0] r;
        axi_write(6'h0C, 32'h1, 0, r);
        axi_write(6'h00, 32'h1, 0, r);
        n_cmp++;
        if (snap_start !== 1'b1 || snap_start1 !== 1'b0) begin
            n_fail++; $display("FAIL start_pulse got %b%b required 10", snap_start, snap_start1);
        end
        chk_reg(6'h04, exp_status(0, 1, 0), "busy_set");
        axi_write(6'h00, 32'h1, 0, r);
        n_cmp++;
        if (snap_start !== 1'b0) begin n_fail++; $display("FAIL start_while_busy got %b required 0", snap_start); end
        done_in = 1; result_in = 32'h7;
        @(posedge clk); #1;
        done_in = 0;
        n_cmp++;
        if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_early got %b required 0", irq[0]); end
        @(posedge clk); #1;
        n_cmp++;
        if (irq[0] !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b required 1", irq[0]); end
        chk_reg(6'h04, exp_status(1, 0, 0), "done_status");
        chk_reg(6'h08, 32'h7, "result");
        axi_write(6'h04, 32'h1, 1, r);
        chk_reg(6'h04, exp_status(1, 0, 0), "done_w1c_collision");
        axi_write(6'h04, 32'h1, 0, r);
        n_cmp++;
        if (irq[0] !== 1'b0) begin n_fail++; $display("FAIL irq_clear got %b required 0", irq[0]); end
        chk_reg(6'h04, exp_status(0, 0, 0), "done_cleared");
    endtask

    task automatic test_soft_clear();
        logic [1:0] r;
        for (int i = 0; i < 5; i++) push(0, $urandom);
        axi_write(6'h00, 32'h1, 0, r);
        n_cmp++;
        if (tvalid[0][0] !== 1'b1) begin n_fail++; $display("FAIL pre_clear_tvalid got %b required 1", tvalid[0][0]); end
        axi_write(6'h00, 32'h2, 0, r);
        n_cmp++;
        if (snap_sclr !== 1'b1 || snap_sclr1 !== 1'b0 || tvalid[0] !== 3'b0) begin
            n_fail++; $display("FAIL soft_clear pulse=%b%b tvalid=%b required 10/000", snap_sclr, snap_sclr1, tvalid[0]);
        end
        clear_model();
        chk_reg(6'h04, exp_status(0, 0, 0), "clear_status");
        chk_reg(6'h08, 32'h7, "clear_keeps_result");
        chk_reg(6'h0C, 32'h1, "clear_keeps_irq_en");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        awaddr = 6'h0C; wdata = 32'h1; awvalid = 1; wvalid = 1;
        do begin @(posedge clk); #1; n++; end while (!aw_rdy[0] && n < 64);
        @(posedge clk); #1;
        awvalid = 0; wvalid = 0;
        n_cmp++;
        if (b_vld[0] !== 1'b1) begin n_fail++; $display("FAIL mid_bvalid_pending got %b required 1", b_vld[0]); end
        rst_n = 0;
        #1;
        n_cmp++;
        if (b_vld[0] !== 1'b0 || aw_rdy[0] !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset_abort bvalid=%b awready=%b required 0/0", b_vld[0], aw_rdy[0]);
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (b_vld[0] !== 1'b0) begin n_fail++; $display("FAIL mid_no_late_b got %b required 0", b_vld[0]); end
        chk_reg(6'h0C, 32'h0, "mid_irq_en_zero");
        chk_reg(6'h08, 32'h0, "mid_result_zero");
        chk_reg(6'h04, exp_status(0, 0, 0), "mid_status_zero");
    endtask

    initial begin
        test_reset();
        test_unmapped();
        test_fifo_fill();
        test_block();
        test_random();
        test_drop();
        test_start_done();
        test_soft_clear();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end
endmodule
